mod_counter: RTL and testbench

- Parametrised modulo up/down counter; successor to the fixed 4-bit counter.
- Adds selectable width and modulo, count direction, wrap or saturate mode, synchronous load/clear, clock-enable prescaler, and terminal-count/status flags.
- Used as a general event/timing counter in sequential test circuits, and as the known-good reference for counter bug checks.

---
 rtl/mod_counter_pkg.sv | 13 +
 rtl/tick_divider.sv | 26 ++
 rtl/mod_counter.sv | 62 ++++++
 tb/tb_mod_counter.sv | 116 +++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// mod_counter_pkg: mode encodings and a constant clog2 helper shared by the counter files
package mod_counter_pkg;
  localparam logic [1:0] MODE_WRAP_UP = 2'b00;
  localparam logic [1:0] MODE_WRAP_DN = 2'b01;
  localparam logic [1:0] MODE_SAT_UP  = 2'b10;
  localparam logic [1:0] MODE_SAT_DN  = 2'b11;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/tick_divider.sv
// tick_divider: prescaler, step pulses every DIV enabled cycles; ports clk, rst_n, en, restart (zeroes prescaler), step
module tick_divider
  import mod_counter_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic step
);
  if (DIV == 1) begin : g_pass
    logic unused;
    assign unused = ^{clk, rst_n, restart};
    assign step = en;
  end else begin : g_div
    localparam int PW = clog2(DIV);
    logic [PW-1:0] pre;
    assign step = en & (pre == PW'(DIV - 1));
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) pre <= '0;
      else if (restart) pre <= '0;
      else if (en) pre <= step ? '0 : pre + PW'(1);
  end
endmodule

// File: rtl/mod_counter.sv
// mod_counter: modulo up/down counter with wrap/saturate, load/clear, prescaler; ports clk, rst_n, en, clr, load, load_val, mode -> count, tc, sat, wrapped
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 2 ** WIDTH - 1,
  parameter int DIV     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             sat,
  output logic             wrapped
);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX_VAL);
  logic             step, up, wrap, at_lim, n_tc, n_wrapped;
  logic [WIDTH-1:0] lim, moved, n_count;
  tick_divider #(.DIV(DIV)) u_div (
    .clk(clk), .rst_n(rst_n), .en(en), .restart(clr | load), .step(step)
  );
  assign up     = (mode == MODE_WRAP_UP) || (mode == MODE_SAT_UP);
  assign wrap   = (mode == MODE_WRAP_UP) || (mode == MODE_WRAP_DN);
  assign lim    = up ? TOP : '0;
  assign at_lim = count == lim;
  // only used away from the limit, so it never relies on 2**WIDTH rollover
  assign moved  = up ? count + WIDTH'(1) : count - WIDTH'(1);
  assign sat    = !wrap && at_lim;
  always_comb begin
    n_count   = count;
    n_tc      = 1'b0;
    n_wrapped = wrapped;
    if (clr) begin
      n_count   = '0;
      n_wrapped = 1'b0;
    end else if (load) begin
      n_count = (load_val > TOP) ? TOP : load_val;
    end else if (step && at_lim && wrap) begin
      n_count   = up ? '0 : TOP;
      n_tc      = 1'b1;
      n_wrapped = 1'b1;
    end else if (step && !at_lim) begin
      n_count = moved;
      n_tc    = !wrap && (moved == lim);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count   <= '0;
      tc      <= 1'b0;
      wrapped <= 1'b0;
    end else begin
      count   <= n_count;
      tc      <= n_tc;
      wrapped <= n_wrapped;
    end
endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: scoreboard bench for mod_counter, one DIV=1 and one DIV=3 instance on shared inputs
module tb_mod_counter;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, clr = 1'b0, load = 1'b0;
  logic [3:0] load_val = '0;
  logic [1:0] mode = 2'b00;
  logic [3:0] c1, c3;
  logic t1, s1, w1, t3, s3, w3;
  int checks = 0, fails = 0;
  typedef struct {
    string nm;
    bit d3;
    logic [3:0] c;
    logic t, s, w;
  } exp_t;
  exp_t q[$];

  mod_counter #(.WIDTH(4), .MAX_VAL(9), .DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .mode(mode), .count(c1), .tc(t1), .sat(s1), .wrapped(w1)
  );
  mod_counter #(.WIDTH(4), .MAX_VAL(9), .DIV(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .mode(mode), .count(c3), .tc(t3), .sat(s3), .wrapped(w3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e = q.pop_front();
      act = e.d3 ? {c3, t3, s3, w3} : {c1, t1, s1, w1};
      checks++;
      if (act !== {e.c, e.t, e.s, e.w}) begin
        fails++;
        $display("FAIL %s: got count=%0d tc=%b sat=%b wrapped=%b, want count=%0d tc=%b sat=%b wrapped=%b",
                 e.nm, act[6:3], act[2], act[1], act[0], e.c, e.t, e.s, e.w);
      end
    end
  end

  task automatic cyc(input string nm, input bit d3, input logic e, c, l, input logic [3:0] lv,
                     input logic [1:0] m, input logic [3:0] xc, input logic xt, xs, xw);
    en = e; clr = c; load = l; load_val = lv; mode = m;
    q.push_back('{nm, d3, xc, xt, xs, xw});
    @(negedge clk);
  endtask

  task automatic direct(input string nm, input logic [2:0] act, input logic [2:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got {count0,tc,wrapped}=%b, want %b", nm, act, want);
    end
  endtask

  initial begin
    cyc("reset", 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++)
      cyc("wrap_up", 0, 1, 0, 0, 0, 2'b00, 4'(i % 10), i == 10, 0, i >= 10);
    cyc("clr_dn", 0, 0, 1, 0, 0, 2'b01, 0, 0, 0, 0);
    cyc("wrap_dn0", 0, 1, 0, 0, 0, 2'b01, 9, 1, 0, 1);
    cyc("wrap_dn1", 0, 1, 0, 0, 0, 2'b01, 8, 0, 0, 1);
    cyc("wrap_dn2", 0, 1, 0, 0, 0, 2'b01, 7, 0, 0, 1);
    cyc("clr_sat", 0, 0, 1, 0, 0, 2'b10, 0, 0, 0, 0);
    cyc("load7", 0, 0, 0, 1, 7, 2'b10, 7, 0, 0, 0);
    cyc("sat_up8", 0, 1, 0, 0, 0, 2'b10, 8, 0, 0, 0);
    cyc("sat_up9", 0, 1, 0, 0, 0, 2'b10, 9, 1, 1, 0);
    cyc("sat_hold", 0, 1, 0, 0, 0, 2'b10, 9, 0, 1, 0);
    cyc("sat_hold2", 0, 1, 0, 0, 0, 2'b10, 9, 0, 1, 0);
    cyc("load15", 0, 0, 0, 1, 15, 2'b10, 9, 0, 1, 0);
    cyc("load3", 0, 0, 0, 1, 3, 2'b10, 3, 0, 0, 0);
    cyc("load_en", 0, 1, 0, 1, 5, 2'b10, 5, 0, 0, 0);
    cyc("after_ld", 0, 1, 0, 0, 0, 2'b10, 6, 0, 0, 0);
    cyc("load1", 0, 0, 0, 1, 1, 2'b11, 1, 0, 0, 0);
    cyc("sat_dn0", 0, 1, 0, 0, 0, 2'b11, 0, 1, 1, 0);
    cyc("sat_dn_hold", 0, 1, 0, 0, 0, 2'b11, 0, 0, 1, 0);
    cyc("mode_chg", 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    cyc("wrap_dn_w", 0, 1, 0, 0, 0, 2'b01, 9, 1, 0, 1);
    cyc("load6", 0, 0, 0, 1, 6, 2'b00, 6, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    direct("async_rst", {c1 == 0, t1, w1}, 3'b100);
    cyc("rst_hold", 0, 0, 0, 0, 0, 2'b11, 0, 0, 1, 0);
    rst_n = 1'b1;
    cyc("resume1", 0, 1, 0, 0, 0, 2'b00, 1, 0, 0, 0);
    cyc("resume2", 0, 1, 0, 0, 0, 2'b00, 2, 0, 0, 0);
    cyc("div_clr", 1, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0);
    cyc("div_e1", 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    cyc("div_e2", 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    cyc("div_idle", 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    cyc("div_e3", 1, 1, 0, 0, 0, 2'b00, 1, 0, 0, 0);
    cyc("div_e4", 1, 1, 0, 0, 0, 2'b00, 1, 0, 0, 0);
    cyc("div_e5", 1, 1, 0, 0, 0, 2'b00, 1, 0, 0, 0);
    cyc("div_e6", 1, 1, 0, 0, 0, 2'b00, 2, 0, 0, 0);
    cyc("div_e7", 1, 1, 0, 0, 0, 2'b00, 2, 0, 0, 0);
    cyc("div_e8", 1, 1, 0, 0, 0, 2'b00, 2, 0, 0, 0);
    cyc("div_midclr", 1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0);
    cyc("div_r1", 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    cyc("div_r2", 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    cyc("div_r3", 1, 1, 0, 0, 0, 2'b00, 1, 0, 0, 0);
    en = 1'b0;
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d entries left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
